// File: rtl/seq_alu_apx.sv
// seq_alu_apx: sequential ALU with single-cycle logic/arith/shift/compare ops,
// a GeAr approximate adder and an iterative radix-2 exact/truncated multiplier.
module seq_alu_apx #(
  parameter int WIDTH     = 32,
  parameter int APX_R     = 2,
  parameter int APX_P     = 6,
  parameter int MUL_TRUNC = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] read_a,
  input  logic [WIDTH-1:0] read_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  localparam int SW   = $clog2(WIDTH);
  localparam int CW   = $clog2(WIDTH + 1);
  localparam int GW   = APX_R + APX_P;
  localparam int NSUB = (WIDTH - APX_P) / APX_R;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  typedef enum logic [3:0] {
    OP_AND = 4'd0, OP_OR = 4'd1, OP_XOR = 4'd2, OP_ADD = 4'd3,
    OP_SUB = 4'd4, OP_ADD_APX = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
    OP_SRA = 4'd8, OP_SLT = 4'd9, OP_SLTU = 4'd10, OP_MUL = 4'd11,
    OP_MUL_APX = 4'd12
  } op_t;

  state_t           state;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    last;
  logic             apx;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ill;
  logic [WIDTH-1:0] apx_sum;
  logic [GW-1:0]    sub;
  logic [SW-1:0]    shamt;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign shamt     = read_x[SW-1:0];
  assign acc_next  = mplier[0] ? acc + mcand : acc;
  assign last      = apx ? CW'(WIDTH - MUL_TRUNC - 1) : CW'(WIDTH - 1);

  // GeAr adder: overlapping sub-adders with zero carry-in; each contributes
  // only its top APX_R bits, sub-adder 0 contributes all of its bits.
  always_comb begin
    apx_sum = '0;
    sub     = '0;
    for (int unsigned i = 0; i < NSUB; i++) begin
      sub = read_a[i*APX_R +: GW] + read_x[i*APX_R +: GW];
      if (i == 0) apx_sum[GW-1:0] = sub;
      else        apx_sum[i*APX_R+APX_P +: APX_R] = sub[GW-1 -: APX_R];
    end
  end

  // Single-cycle operation result and illegal-op decode
  always_comb begin
    alu_res = '0;
    alu_ill = 1'b0;
    case (op)
      OP_AND:     alu_res = read_a & read_x;
      OP_OR:      alu_res = read_a | read_x;
      OP_XOR:     alu_res = read_a ^ read_x;
      OP_ADD:     alu_res = read_a + read_x;
      OP_SUB:     alu_res = read_a - read_x;
      OP_ADD_APX: alu_res = apx_sum;
      OP_SLL:     alu_res = read_a << shamt;
      OP_SRL:     alu_res = read_a >> shamt;
      OP_SRA:     alu_res = $signed(read_a) >>> shamt;
      OP_SLT:     alu_res = {{(WIDTH-1){1'b0}}, ($signed(read_a) < $signed(read_x))};
      OP_SLTU:    alu_res = {{(WIDTH-1){1'b0}}, (read_a < read_x)};
      OP_MUL,
      OP_MUL_APX: alu_res = '0;
      default:    alu_ill = 1'b1;
    endcase
  end

  // Control FSM, multiplier datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      result  <= '0;
      zero    <= 1'b0;
      illegal <= 1'b0;
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      apx     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (op == OP_MUL || op == OP_MUL_APX) begin
              state <= MUL;
              acc   <= '0;
              cnt   <= '0;
              apx   <= (op == OP_MUL_APX);
              // Truncated multiply skips the low multiplier bits entirely by
              // pre-shifting both operands, so fewer iterations are needed.
              if (op == OP_MUL_APX) begin
                mcand  <= read_a << MUL_TRUNC;
                mplier <= read_x >> MUL_TRUNC;
              end else begin
                mcand  <= read_a;
                mplier <= read_x;
              end
            end else begin
              state   <= DONE;
              result  <= alu_res;
              zero    <= (alu_res == '0);
              illegal <= alu_ill;
            end
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == last) begin
            state   <= DONE;
            result  <= acc_next;
            zero    <= (acc_next == '0);
            illegal <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu_apx.sv
// tb_seq_alu_apx: table vectors, hand-written corner sequences and random
// stimulus against a behavioural model of seq_alu_apx (default parameters).
module tb_seq_alu_apx;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [31:0] read_a;
  logic [31:0] read_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  seq_alu_apx #(.WIDTH(32), .APX_R(2), .APX_P(6), .MUL_TRUNC(8)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .read_a(read_a), .read_x(read_x), .out_valid(out_valid),
    .out_ready(out_ready), .result(result), .zero(zero), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] x;
    logic [31:0] res;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // GeAr(32,2,6) from its definition: 13 windows of 8 bits at stride 2.
  function automatic logic [31:0] gear(input logic [31:0] a, input logic [31:0] x);
    longint unsigned r = 0;
    longint unsigned s;
    for (int i = 0; i < 13; i++) begin
      s = ((longint'(a) >> (2*i)) & 64'hFF) + ((longint'(x) >> (2*i)) & 64'hFF);
      if (i == 0) r = r | (s & 64'hFF);
      else        r = r | (((s >> 6) & 64'h3) << (2*i + 6));
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] x);
    logic [63:0] p;
    int sh = int'(x[4:0]);
    case (o)
      4'd0:  return a & x;
      4'd1:  return a | x;
      4'd2:  return a ^ x;
      4'd3:  return a + x;
      4'd4:  return a - x;
      4'd5:  return gear(a, x);
      4'd6:  return a << sh;
      4'd7:  return a >> sh;
      4'd8:  return $signed(a) >>> sh;
      4'd9:  return ($signed(a) < $signed(x)) ? 32'd1 : 32'd0;
      4'd10: return (a < x) ? 32'd1 : 32'd0;
      4'd11: begin p = 64'(a) * 64'(x); return p[31:0]; end
      4'd12: begin p = 64'(a) * 64'(x & 32'hFFFF_FF00); return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  // Issue one request, measure latency, check outputs, then consume.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] x,
                        input logic [31:0] exp, input string name);
    int lat;
    int n;
    int exp_lat;
    logic rdy_seen;
    exp_lat = (o == 4'd11) ? 33 : (o == 4'd12) ? 25 : 1;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    check({name, "_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; op = o; read_a = a; read_x = x; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    read_a = $urandom; read_x = $urandom; op = 4'($urandom_range(0, 15));
    lat = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 200) begin
      if (in_ready) rdy_seen = 1'b1;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    check({name, "_busy_ready"}, 64'(rdy_seen | in_ready), 64'd0);
    check({name, "_res"}, 64'(result), 64'(exp));
    check({name, "_zero"}, 64'(zero), 64'(exp == 32'd0));
    check({name, "_ill"}, 64'(illegal), 64'(o >= 4'd13));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({name, "_back_idle"}, 64'({in_ready, out_valid}), 64'b10);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rx;
    int n;

    vecs[0]  = '{4'd5,  32'h0000_00FF, 32'h0000_0001, 32'h0000_0000};
    vecs[1]  = '{4'd5,  32'h0000_000F, 32'h0000_0001, 32'h0000_0010};
    vecs[2]  = '{4'd3,  32'h0000_00FF, 32'h0000_0001, 32'h0000_0100};
    vecs[3]  = '{4'd11, 32'h0001_0003, 32'h0000_0005, 32'h0005_000F};
    vecs[4]  = '{4'd12, 32'h0000_0003, 32'h0000_0105, 32'h0000_0300};
    vecs[5]  = '{4'd9,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001};
    vecs[6]  = '{4'd10, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[7]  = '{4'd8,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000};
    vecs[8]  = '{4'd14, 32'h0000_1234, 32'h0000_5678, 32'h0000_0000};
    vecs[9]  = '{4'd4,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    vecs[10] = '{4'd6,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000};
    vecs[11] = '{4'd7,  32'h8000_0000, 32'h0000_0021, 32'h4000_0000};
    vecs[12] = '{4'd0,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};
    vecs[13] = '{4'd2,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0};
    vecs[14] = '{4'd1,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0};
    vecs[15] = '{4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001};

    reset_n = 1'b0; in_valid = 1'b0; op = '0; read_a = '0; read_x = '0; out_ready = 1'b0;
    #12;
    check("reset_state", 64'({in_ready, out_valid, zero, illegal}), 64'b1000);
    check("reset_result", 64'(result), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].x, vecs[i].res, $sformatf("vec%0d", i));

    // Hold: result stays put while out_ready is low, new requests ignored.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd3; read_a = 32'd7; read_x = 32'd8;
    @(posedge clk); #1;
    op = 4'd0; read_a = 32'h0; read_x = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("hold%0d", c), 64'({out_valid, in_ready, zero, illegal, result}),
            64'({1'b1, 1'b0, 1'b0, 1'b0, 32'd15}));
    end
    in_valid = 1'b0;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;

    // Reset mid-multiply aborts asynchronously.
    @(negedge clk);
    in_valid = 1'b1; op = 4'd11; read_a = 32'h1234_5678; read_x = 32'h9ABC_DEF1;
    @(posedge clk); #1; in_valid = 1'b0;
    n = 0;
    repeat (10) @(posedge clk);
    #3;
    check("mid_mul_busy", 64'({in_ready, out_valid, result}), 64'({1'b0, 1'b0, 32'd15}));
    reset_n = 1'b0;
    #1;
    check("async_reset", 64'({out_valid, result, zero, illegal}), 64'd0);
    @(negedge clk); reset_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_abort", 64'({in_ready, out_valid}), 64'b10);
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) n++;
    end
    check("no_result_after_abort", 64'(n), 64'd0);

    // Random operations against the model.
    for (int i = 0; i < 60; i++) begin
      ro = 4'($urandom_range(0, 15));
      ra = $urandom;
      rx = (i % 5 == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      run_op(ro, ra, rx, model(ro, ra, rx), $sformatf("rnd%0d_op%0d", i, ro));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
